// File: rtl/level_column_feeder.sv
// level_column_feeder: scroll tracker and level-column fetcher for the 10-column block array.
// After reset it preloads columns 0..9, then fetches one column per 40-pixel block scrolled.
// Optional build macro FEEDER_END_PAD_EN: scroll past the level end, feeding air columns.
// ADDR_W must also hold LEVEL_COLS + 9 when FEEDER_END_PAD_EN is defined.
module level_column_feeder #(
  parameter int unsigned LEVEL_COLS = 320,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned BLOCK_PX   = 40
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              scroll_req,
  input  logic [2:0]        scroll_step,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [29:0]       rom_data,
  output logic              Shift,
  output logic [29:0]       new_block_id,
  output logic [5:0]        fine_offset,
  output logic [ADDR_W-1:0] col_index,
  output logic              ready,
  output logic              level_end
);

  localparam logic [ADDR_W-1:0] PreloadLast = ADDR_W'(9);
  localparam logic [5:0]        BlockPx     = 6'(BLOCK_PX);
`ifdef FEEDER_END_PAD_EN
  localparam logic [ADDR_W-1:0] EndCol      = ADDR_W'(LEVEL_COLS);
`else
  localparam logic [ADDR_W-1:0] EndCol      = ADDR_W'(LEVEL_COLS - 10);
`endif

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StShift} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [5:0]          fine_q, fine_d;
  logic [29:0]         blk_q, blk_d;
  logic                ready_q, ready_d;
  logic [5:0]          sum;
  logic                rom_hit;

  // Columns beyond the level are air and need no ROM access.
`ifdef FEEDER_END_PAD_EN
  assign rom_hit = (next_addr_q < ADDR_W'(LEVEL_COLS));
`else
  assign rom_hit = 1'b1;
`endif

  assign sum = fine_q + {3'b000, scroll_step};

  // State and datapath registers; reset lands in StFetch so preload starts immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StFetch;
      next_addr_q <= '0;
      col_q       <= '0;
      fine_q      <= '0;
      blk_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      col_q       <= col_d;
      fine_q      <= fine_d;
      blk_q       <= blk_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state: scroll accounting in idle, fetch/capture/shift sequence otherwise.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    col_d       = col_q;
    fine_d      = fine_q;
    blk_d       = blk_q;
    ready_d     = ready_q;
    unique case (state_q)
      StIdle: begin
        if (ready_q && frame_tick && scroll_req && !level_end) begin
          if (sum >= BlockPx) begin
            fine_d  = sum - BlockPx;
            state_d = StFetch;
          end else begin
            fine_d  = sum;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        blk_d   = rom_hit ? rom_data : 30'h0;
        state_d = StShift;
      end
      StShift: begin
        next_addr_d = next_addr_q + ADDR_W'(1);
        if (ready_q) begin
          col_d   = col_q + ADDR_W'(1);
          state_d = StIdle;
        end else if (next_addr_q == PreloadLast) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          // Preload chains fetches back to back for 3-cycle shift spacing.
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are gated by Reset so they drop the instant reset asserts.
  always_comb begin
    rom_rd       = (state_q == StFetch) && rom_hit && !Reset;
    Shift        = (state_q == StShift) && !Reset;
    rom_addr     = next_addr_q;
    new_block_id = blk_q;
    fine_offset  = fine_q;
    col_index    = col_q;
    ready        = ready_q;
    level_end    = (col_q == EndCol);
  end

endmodule

// File: tb/tb_level_column_feeder.sv
// Bench for level_column_feeder with a 12-column level and a synchronous ROM model.
module tb_level_column_feeder;

  localparam int LC = 12;
`ifdef FEEDER_END_PAD_EN
  localparam int END_COL = LC;
`else
  localparam int END_COL = LC - 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, scroll_req;
  logic [2:0]  scroll_step;
  logic        rom_rd, shift, ready, level_end;
  logic [8:0]  rom_addr, col_index;
  logic [29:0] rom_data, new_block_id;
  logic [5:0]  fine_offset;

  int checks = 0;
  int errors = 0;
  int n_shift = 0;
  logic shift_prev = 1'b0;

  int addr_q[$];
  logic [29:0] word_q[$];

  int m_fine, m_col, m_next;
  logic m_ready;
  logic [29:0] m_last;

  always #5 clk = ~clk;

  level_column_feeder #(.LEVEL_COLS(LC), .ADDR_W(9), .BLOCK_PX(40)) dut (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .scroll_req(scroll_req),
    .scroll_step(scroll_step), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .Shift(shift), .new_block_id(new_block_id), .fine_offset(fine_offset),
    .col_index(col_index), .ready(ready), .level_end(level_end)
  );

  function automatic logic [29:0] rom_word(input int a);
    logic [31:0] v;
    v = (a * 32'h0123_4567) ^ 32'h2AAA_5555;
    return v[29:0];
  endfunction

  always @(posedge clk) if (rom_rd) rom_data <= rom_word(int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ROM strobe and every Shift is matched against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_rd) begin
        if (addr_q.size() == 0) chk("rom_rd_unexpected", {31'b0, rom_rd}, 32'd0);
        else chk("rom_addr", {23'b0, rom_addr}, addr_q.pop_front());
      end
      if (shift) begin
        n_shift++;
        chk("shift_gap", {31'b0, shift_prev}, 32'd0);
        if (word_q.size() == 0) chk("shift_unexpected", {31'b0, shift}, 32'd0);
        else chk("new_block_id", {2'b0, new_block_id}, {2'b0, word_q.pop_front()});
      end
      shift_prev <= shift;
    end else begin
      shift_prev <= 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rom_rd", {31'b0, rom_rd}, 0);
    chk("rst_shift", {31'b0, shift}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_level_end", {31'b0, level_end}, 0);
    chk("rst_rom_addr", {23'b0, rom_addr}, 0);
    chk("rst_block", {2'b0, new_block_id}, 0);
    chk("rst_fine", {26'b0, fine_offset}, 0);
    chk("rst_col", {23'b0, col_index}, 0);
    addr_q.delete();
    word_q.delete();
    for (int i = 0; i < 10; i++) begin
      addr_q.push_back(i);
      word_q.push_back(rom_word(i));
    end
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle 1 is the first cycle after reset release.
  task automatic check_preload();
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("pre_rom_rd", {31'b0, rom_rd}, {31'b0, (i % 3 == 1) && (i <= 28)});
      chk("pre_shift", {31'b0, shift}, {31'b0, (i % 3 == 0) && (i <= 30)});
      chk("pre_ready", {31'b0, ready}, {31'b0, i == 31});
      chk("pre_col", {23'b0, col_index}, 0);
    end
    chk("pre_drain", word_q.size(), 0);
    m_ready = 1'b1; m_fine = 0; m_col = 0; m_next = 10; m_last = rom_word(9);
  endtask

  task automatic model_step(input int step, input logic req);
    int sum;
    if (m_ready && req && m_col != END_COL) begin
      sum = m_fine + step;
      if (sum >= 40) begin
        m_fine = sum - 40;
        if (m_next < LC) begin
          addr_q.push_back(m_next);
          m_last = rom_word(m_next);
        end else begin
          m_last = 30'h0;
        end
        word_q.push_back(m_last);
        m_next++;
        m_col++;
      end else begin
        m_fine = sum;
      end
    end
  endtask

  task automatic pulse(input logic [2:0] step, input logic req);
    @(posedge clk);
    #1 frame_tick = 1'b1; scroll_step = step; scroll_req = req;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic tick(input logic [2:0] step, input logic req);
    model_step(int'(step), req);
    pulse(step, req);
    repeat (4) @(negedge clk);
    chk("tick_fine", {26'b0, fine_offset}, m_fine);
    chk("tick_col", {23'b0, col_index}, m_col);
    chk("tick_level_end", {31'b0, level_end}, {31'b0, m_col == END_COL});
    chk("tick_block_hold", {2'b0, new_block_id}, {2'b0, m_last});
  endtask

  initial begin
    int shifts_before;
    frame_tick = 1'b0; scroll_req = 1'b0; scroll_step = 3'd0;
    do_reset();
    check_preload();

    repeat (5) tick(3'd7, 1'b1);
    chk("fine_35", {26'b0, fine_offset}, 35);
    tick(3'd3, 1'b0);
    tick(3'd0, 1'b1);

    // Sixth tick crosses a block boundary; check exact latency.
    model_step(7, 1'b1);
    pulse(3'd7, 1'b1);
    @(negedge clk);
    chk("lat_fine", {26'b0, fine_offset}, 2);
    chk("lat_rom_rd", {31'b0, rom_rd}, 1);
    @(negedge clk);
    chk("lat_wait_rd", {31'b0, rom_rd}, 0);
    chk("lat_wait_shift", {31'b0, shift}, 0);
    @(negedge clk);
    chk("lat_shift", {31'b0, shift}, 1);
    chk("lat_block", {2'b0, new_block_id}, {2'b0, rom_word(10)});
    chk("lat_col_before", {23'b0, col_index}, 0);
    @(negedge clk);
    chk("lat_shift_low", {31'b0, shift}, 0);
    chk("lat_col_after", {23'b0, col_index}, 1);

    repeat (5) tick(3'd7, 1'b1);
    chk("fine_37", {26'b0, fine_offset}, 37);

    // Second tick lands while the FSM is in FETCH and must be dropped.
    shifts_before = n_shift;
    model_step(7, 1'b1);
    @(posedge clk);
    #1 frame_tick = 1'b1; scroll_step = 3'd7; scroll_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_fine", {26'b0, fine_offset}, m_fine);
    chk("ign_col", {23'b0, col_index}, m_col);
    chk("ign_shifts", n_shift - shifts_before, 1);
    chk("ign_level_end", {31'b0, level_end}, {31'b0, m_col == END_COL});

    repeat (70) tick(3'd7, 1'b1);
    chk("end_col", {23'b0, col_index}, END_COL);
    chk("end_flag", {31'b0, level_end}, 1);

    // Reset from a scrolled state, then again mid-preload during WAIT.
    do_reset();
    repeat (2) @(negedge clk);
    do_reset();
    check_preload();
    tick(3'd7, 1'b1);

    chk("final_drain", word_q.size() + addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
